// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES inverse cipher, one round per clock
//
// Purpose: FIPS-197 decryption for AES-128/192/256, one round per clock edge.
// It consumes a pre-expanded round-key schedule and has valid/ready handshakes
// on both the ciphertext and plaintext sides.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   ciphertext block valid
//   in_ready   block can be accepted (IDLE and not in reset)
//   in_data    ciphertext, bit 127 is byte 0 (state[0][0])
//   key_sched  round key r at bits [128*r+127 : 128*r]
//   size       00=AES-128, 01=AES-192, 10=AES-256, 11 treated as 00
//   out_valid  plaintext valid (registered)
//   out_ready  downstream accepts the plaintext
//   out_data   plaintext (registered, zero outside DONE)

module aes_inv_cipher_iter #(
  parameter int NR_MAX = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [127:0]                  in_data,
  input  logic [128*(NR_MAX+1)-1:0]     key_sched,
  input  logic [1:0]                    size,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [127:0]                  out_data
);

  // FIPS-197 inverse S-box. Entry 0x00 sits in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         r_fsm;
  logic [3:0]     r_rnd;
  logic [127:0]   r_state;
  logic           r_out_valid;
  logic [127:0]   r_out_data;

  logic [3:0]     w_nr;
  logic [127:0]   w_rk_init;
  logic [127:0]   w_rk_rnd;
  logic [127:0]   w_ark;
  logic [127:0]   w_round;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns; a0 (row 0) is the top byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // InvShiftRows then InvSubBytes. Byte n of the block is state[n%4][n/4];
  // row r is rotated right by r, so dst[r][c] = src[r][(c-r) mod 4].
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    int src;
    int dst;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        dst = r + 4*c;
        src = r + 4*((c - r + 4) % 4);
        o[127-8*dst -: 8] = inv_sbox(s[127-8*src -: 8]);
      end
    end
    return o;
  endfunction

  always_comb begin
    case (size)
      2'b01:   w_nr = 4'd12;
      2'b10:   w_nr = 4'd14;
      default: w_nr = 4'd10;
    endcase
  end

  // Round-key selection: rk[Nr] for the initial AddRoundKey, rk[rnd] per round.
  always_comb begin
    w_rk_init = '0;
    w_rk_rnd  = '0;
    for (int i = 0; i <= NR_MAX; i++) begin
      if (w_nr == 4'(i))  w_rk_init = key_sched[128*i +: 128];
      if (r_rnd == 4'(i)) w_rk_rnd  = key_sched[128*i +: 128];
    end
  end

  // The final round (rnd==0) skips InvMixColumns.
  always_comb begin
    w_ark   = inv_shift_sub(r_state) ^ w_rk_rnd;
    w_round = (r_rnd == 4'd0) ? w_ark : inv_mix_cols(w_ark);
  end

  // Nr only matters at acceptance (rk[Nr] and the rnd start value), so
  // loading rnd with Nr-1 captures size for the whole block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_rnd       <= 4'd0;
      r_state     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= in_data ^ w_rk_init;
            r_rnd   <= w_nr - 4'd1;
            r_fsm   <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_state <= w_round;
          if (r_rnd == 4'd0) begin
            r_out_data  <= w_round;
            r_out_valid <= 1'b1;
            r_fsm       <= S_DONE;
          end else begin
            r_rnd <= r_rnd - 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_fsm       <= S_IDLE;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_fsm == S_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
